pe_dot_sequencer: RTL

// - Sequences one PE_v4_dsp vector PE (VECTOR lanes, 1-cycle registered MAC, c_ab = a*b + c)
//   to compute a K-beat vector dot-product accumulation: res[l] = bias[l] + sum_k a_k[l]*b_k.
// - Sits between the operand buffers (valid/ready stream) and the PE, and closes the

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_dot_sequencer_if.sv | 33 +++
 rtl/pe_dot_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and default sizing for the PE dot-product sequencer.
package pe_pkg;

  localparam int DFLT_REG_WIDTH = 16;
  localparam int DFLT_VECTOR    = 4;
  localparam int DFLT_K_W       = 8;

  typedef logic [DFLT_VECTOR-1:0][DFLT_REG_WIDTH-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/pe_dot_sequencer_if.sv
// Operand stream, PE feed/feedback and result stream for the dot-product sequencer.
interface pe_dot_sequencer_if
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = DFLT_REG_WIDTH,
  parameter int VECTOR    = DFLT_VECTOR
) ();

  logic                              opnd_valid;
  logic                              opnd_ready;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  opnd_a;
  logic [REG_WIDTH-1:0]              opnd_b;

  logic [VECTOR-1:0][REG_WIDTH-1:0]  pe_a;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  pe_b;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  pe_c;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  pe_c_ab;

  logic                              res_valid;
  logic                              res_ready;
  logic [VECTOR-1:0][REG_WIDTH-1:0]  res_data;

  modport master (
    input  opnd_valid, opnd_a, opnd_b, pe_c_ab, res_ready,
    output opnd_ready, pe_a, pe_b, pe_c, res_valid, res_data
  );

  modport slave (
    output opnd_valid, opnd_a, opnd_b, pe_c_ab, res_ready,
    input  opnd_ready, pe_a, pe_b, pe_c, res_valid, res_data
  );

endinterface

// File: rtl/pe_dot_sequencer.sv
// Drives an external vector MAC PE through a K-beat accumulation and hands out the result.
//
// state | meaning
// IDLE  | waiting for start, PE inputs held at zero
// PRIME | one cycle loading bias into the PE accumulator
// RUN   | accepting operand beats, bubbles on stalls, c_ab fed back to c
// DRAIN | one cycle capturing the final c_ab into res_data
// OUT   | result held valid until the consumer takes it
module pe_dot_sequencer
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = DFLT_REG_WIDTH,
  parameter int VECTOR    = DFLT_VECTOR,
  parameter int K_W       = DFLT_K_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [K_W-1:0]                   cfg_k,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0] bias_c,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  pe_dot_sequencer_if.master               bus
);

  state_t                           state_q, state_d;
  logic [K_W-1:0]                   k_q;
  logic [K_W-1:0]                   cnt_q, cnt_d, cnt_inc;
  logic [VECTOR-1:0][REG_WIDTH-1:0] bias_q;
  logic [VECTOR-1:0][REG_WIDTH-1:0] res_q;
  logic                             capture;
  logic                             res_load;

  logic                             opnd_ready;
  logic                             res_valid;
  logic [VECTOR-1:0][REG_WIDTH-1:0] pe_a, pe_b, pe_c;

  assign cnt_inc = cnt_q + K_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      bias_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        k_q    <= cfg_k;
        bias_q <= bias_c;
      end
      if (res_load) res_q <= bus.pe_c_ab;
    end
  end

  // Abort wins over a same-cycle beat or result handshake, so it gates ready/valid too.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    res_load   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    opnd_ready = 1'b0;
    res_valid  = 1'b0;
    pe_a       = '0;
    pe_b       = '0;
    pe_c       = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        pe_c = bias_q;
        if (abort)            state_d = IDLE;
        else if (k_q != '0)   state_d = RUN;
        else                  state_d = DRAIN;
      end
      RUN: begin
        pe_c = bus.pe_c_ab;
        if (abort) begin
          state_d = IDLE;
        end else begin
          opnd_ready = 1'b1;
          if (bus.opnd_valid) begin
            pe_a  = bus.opnd_a;
            pe_b  = {VECTOR{bus.opnd_b}};
            cnt_d = cnt_inc;
            if (cnt_inc == k_q) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        pe_c = bus.pe_c_ab;
        if (abort) begin
          state_d = IDLE;
        end else begin
          res_load = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          res_valid = 1'b1;
          if (bus.res_ready) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.opnd_ready = opnd_ready;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_q;
  assign bus.pe_a       = pe_a;
  assign bus.pe_b       = pe_b;
  assign bus.pe_c       = pe_c;

endmodule
